// File: rtl/fft_bitrev_buf_pkg.sv
// Shared widths, sample bundle and bit-reverse helper
// for the FFT input reorder buffer.
package fft_bitrev_buf_pkg;

  localparam int FFT_DATA_WD  = 10;
  localparam int FFT_PTS_LOG2 = 6;
  localparam int FFT_PTS      = 1 << FFT_PTS_LOG2;

  typedef logic [FFT_PTS_LOG2-1:0] idx_t;
  typedef logic [FFT_DATA_WD-1:0]  smp_t;

  typedef struct packed {
    smp_t re;
    smp_t im;
  } cplx_t;

  localparam idx_t IDX_LAST = idx_t'(FFT_PTS - 1);

  function automatic idx_t bitrev(input idx_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < FFT_PTS_LOG2; i++)
      r[i] = v[FFT_PTS_LOG2-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_buf_if.sv
// Sample-in / sample-out valid-ready bundle of the
// bit-reverse buffer.
interface fft_bitrev_buf_if;
  import fft_bitrev_buf_pkg::*;

  logic din_vld;
  logic din_rdy;
  logic din_last;
  smp_t din_re;
  smp_t din_im;

  logic dout_vld;
  logic dout_rdy;
  logic dout_last;
  idx_t dout_idx;
  smp_t dout_re;
  smp_t dout_im;

  modport master (
    output din_vld, din_last,
    output din_re, din_im,
    output dout_rdy,
    input  din_rdy, dout_vld,
    input  dout_last, dout_idx,
    input  dout_re, dout_im
  );

  modport slave (
    input  din_vld, din_last,
    input  din_re, din_im,
    input  dout_rdy,
    output din_rdy, dout_vld,
    output dout_last, dout_idx,
    output dout_re, dout_im
  );

endinterface

// File: rtl/fft_pingpong_mem.sv
// Two-bank sample store: one synchronous write port,
// one combinational read port, contents not reset.
module fft_pingpong_mem
  import fft_bitrev_buf_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  logic  wr_bank,
  input  idx_t  wr_addr,
  input  cplx_t wr_data,
  input  logic  rd_bank,
  input  idx_t  rd_addr,
  output cplx_t rd_data
);

  cplx_t mem [2][FFT_PTS];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer: frames in natural order,
// frames out in bit-reversed order.
module fft_bitrev_buf
  import fft_bitrev_buf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fft_bitrev_buf_if.slave bus,
  output logic err_frame
);

  idx_t       wr_cnt;
  idx_t       rd_cnt;
  idx_t       rd_addr;
  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_fire;
  logic       rd_fire;
  logic       wr_wrap;
  logic       rd_wrap;
  cplx_t      wr_data;
  cplx_t      rd_data;

  assign bus.din_rdy  = !full[wr_bank];
  assign bus.dout_vld = full[rd_bank];

  assign wr_fire = bus.din_vld & bus.din_rdy;
  assign rd_fire = bus.dout_vld & bus.dout_rdy;
  assign wr_wrap = (wr_cnt == IDX_LAST);
  assign rd_wrap = (rd_cnt == IDX_LAST);

  assign wr_data = {bus.din_re, bus.din_im};
  assign rd_addr = bitrev(rd_cnt);

  fft_pingpong_mem u_mem (
    .clk     (clk),
    .we      (wr_fire),
    .wr_bank (wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Fill and drain always hit different banks,
  // so both updates can land in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_wrap)
      full_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_wrap)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      err_frame <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_wrap)
          wr_bank <= ~wr_bank;
        if (bus.din_last != wr_wrap)
          err_frame <= 1'b1;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_wrap)
          rd_bank <= ~rd_bank;
      end
    end
  end

  assign bus.dout_re   = bus.dout_vld ? rd_data.re : '0;
  assign bus.dout_im   = bus.dout_vld ? rd_data.im : '0;
  assign bus.dout_idx  = bus.dout_vld ? rd_addr : '0;
  assign bus.dout_last = bus.dout_vld & rd_wrap;

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Scoreboard bench for fft_bitrev_buf: frames written
// in natural order are expected back bit-reversed.
module tb_fft_bitrev_buf;
  import fft_bitrev_buf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic err_frame;

  fft_bitrev_buf_if bus ();

  fft_bitrev_buf dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] re;
    logic [9:0] im;
    logic [5:0] idx;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic       vld;
    logic [9:0] re;
    logic [9:0] im;
    logic [5:0] idx;
    logic       last;
  } obs_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_total = 0;
  logic [9:0] fre [64];
  logic [9:0] fim [64];
  int   wcnt = 0;

  logic s_din_rdy, s_dout_vld, s_dout_last;
  logic s_rd_fire, s_wr_fire;

  function automatic logic [5:0] ref_rev(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  function automatic void model_write(input logic [9:0] re,
                                      input logic [9:0] im);
    exp_t e;
    fre[wcnt] = re;
    fim[wcnt] = im;
    wcnt++;
    if (wcnt == 64) begin
      for (int j = 0; j < 64; j++) begin
        e.idx  = ref_rev(6'(j));
        e.re   = fre[e.idx];
        e.im   = fim[e.idx];
        e.last = (j == 63);
        exp_q.push_back(e);
      end
      wcnt = 0;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    wcnt = 0;
  endfunction

  // Inputs change 2ns after posedge; everything is observed at negedge.
  task automatic step(input logic vld, input logic [9:0] re,
                      input logic [9:0] im, input logic last,
                      input logic rdy);
    bus.din_vld  = vld;
    bus.din_re   = re;
    bus.din_im   = im;
    bus.din_last = last;
    bus.dout_rdy = rdy;
    @(negedge clk);
    s_din_rdy   = bus.din_rdy;
    s_dout_vld  = bus.dout_vld;
    s_dout_last = bus.dout_last;
    s_rd_fire   = bus.dout_vld & rdy;
    s_wr_fire   = vld & bus.din_rdy;
    if (s_wr_fire && !rst)
      model_write(re, im);
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget, input int rdy_pct,
                       output bit done, output int lasts,
                       output int gaps);
    done  = 0;
    lasts = 0;
    gaps  = 0;
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0) break;
      step(1'b0, 10'd0, 10'd0, 1'b0,
           1'($urandom_range(99) < rdy_pct));
      if (s_rd_fire && s_dout_last) lasts++;
      if (!s_dout_vld) gaps++;
    end
    done = (exp_q.size() == 0);
  endtask

  obs_t cur, prev;
  exp_t mon_e;
  bit   prev_stall = 0;

  always @(negedge clk) begin
    cur = '{bus.dout_vld, bus.dout_re, bus.dout_im,
            bus.dout_idx, bus.dout_last};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (cur !== prev) begin
          n_fail++;
          $display("FAIL stall_hold got %h exp %h", cur, prev);
        end
      end
      if (!cur.vld) begin
        n_checks++;
        if (cur !== '0) begin
          n_fail++;
          $display("FAIL idle_zero got %h exp 0", cur);
        end
      end else if (bus.dout_rdy) begin
        rd_total++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat got %h exp none", cur);
        end else begin
          mon_e = exp_q.pop_front();
          if ({cur.re, cur.im, cur.idx, cur.last} !== mon_e) begin
            n_fail++;
            $display("FAIL dout_beat got %h exp %h",
                     {cur.re, cur.im, cur.idx, cur.last}, mon_e);
          end
        end
      end
      prev_stall = cur.vld && !bus.dout_rdy;
      prev = cur;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    n_checks++;
    if (bus.din_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_din_rdy got %b exp 1", bus.din_rdy);
    end
    n_checks++;
    if (bus.dout_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dout_vld got %b exp 0", bus.dout_vld);
    end
    n_checks++;
    if ({bus.dout_re, bus.dout_im, bus.dout_idx, bus.dout_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_dout got %h exp 0",
               {bus.dout_re, bus.dout_im, bus.dout_idx, bus.dout_last});
    end
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b exp 0", err_frame);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_one_frame();
    int  acc;
    bit  done;
    int  lasts, gaps;
    logic vld_at_last;
    acc = 0;
    vld_at_last = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 10'(k), 10'(-k), 1'(k == 63), 1'b1);
      if (s_wr_fire) acc++;
      if (k == 63) vld_at_last = s_dout_vld;
    end
    n_checks++;
    if (acc != 64 || vld_at_last !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_write got acc=%0d vld=%b exp acc=64 vld=0",
               acc, vld_at_last);
    end
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
    n_checks++;
    if (s_dout_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL first_latency got vld=%b exp 1", s_dout_vld);
    end
    lasts = (s_rd_fire && s_dout_last) ? 1 : 0;
    drain(200, 100, done, acc, gaps);
    lasts += acc;
    n_checks++;
    if (!done || lasts != 1 || gaps != 0) begin
      n_fail++;
      $display("FAIL frame_drain got done=%0b lasts=%0d gaps=%0d exp 1 1 0",
               done, lasts, gaps);
    end
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err got %b exp 0", err_frame);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    bit seen, chk_next;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 10'($urandom_range(1023)), 10'($urandom_range(1023)),
           1'(wcnt == 63), 1'b0);
      if (s_wr_fire) acc++;
    end
    n_checks++;
    if (acc != 128 || s_din_rdy !== 1'b0 || exp_q.size() != 128) begin
      n_fail++;
      $display("FAIL bp_accept got acc=%0d rdy=%b q=%0d exp 128 0 128",
               acc, s_din_rdy, exp_q.size());
    end
    seen = 0;
    chk_next = 0;
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
      if (chk_next) begin
        chk_next = 0;
        n_checks++;
        if (s_din_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_rdy_return got %b exp 1", s_din_rdy);
        end
      end
      if (!seen && s_rd_fire && s_dout_last) begin
        seen = 1;
        chk_next = 1;
        n_checks++;
        if (s_din_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_rdy_early got %b exp 0", s_din_rdy);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || !seen) begin
      n_fail++;
      $display("FAIL bp_drain got left=%0d seen=%0b exp 0 1",
               exp_q.size(), seen);
    end
  endtask

  task automatic test_overlap();
    int  acc, cyc, frm, gaps, rd0, lasts, g2;
    bit  started, done, coincide;
    acc = 0; cyc = 0; gaps = 0; started = 0; coincide = 0;
    rd0 = rd_total;
    while (acc < 640 && cyc < 1000) begin
      frm = acc / 64;
      step(1'b1, 10'($urandom_range(1023)), 10'($urandom_range(1023)),
           1'(wcnt == 63), 1'b1);
      cyc++;
      if (s_wr_fire) begin
        if (frm == 1 && (acc % 64) == 63)
          coincide = s_rd_fire && s_dout_last;
        acc++;
      end
      if (s_rd_fire) started = 1;
      else if (started) gaps++;
    end
    n_checks++;
    if (acc != 640 || cyc != 640) begin
      n_fail++;
      $display("FAIL ovl_write got acc=%0d cyc=%0d exp 640 640", acc, cyc);
    end
    n_checks++;
    if (!coincide) begin
      n_fail++;
      $display("FAIL ovl_coincide got 0 exp 1");
    end
    drain(400, 100, done, lasts, g2);
    gaps += g2;
    n_checks++;
    if (!done || gaps != 0 || rd_total - rd0 != 640) begin
      n_fail++;
      $display("FAIL ovl_stream got done=%0b gaps=%0d reads=%0d exp 1 0 640",
               done, gaps, rd_total - rd0);
    end
  endtask

  task automatic test_framing();
    int  acc, cyc, lasts, gaps;
    bit  done;
    for (int k = 0; k < 64; k++) begin
      if (k == 10) begin
        n_checks++;
        if (err_frame !== 1'b0) begin
          n_fail++;
          $display("FAIL err_before got %b exp 0", err_frame);
        end
      end
      step(1'b1, 10'($urandom_range(1023)), 10'($urandom_range(1023)),
           1'(k == 10), 1'b1);
      if (k == 10) begin
        n_checks++;
        if (err_frame !== 1'b1) begin
          n_fail++;
          $display("FAIL err_set got %b exp 1", err_frame);
        end
      end
    end
    for (int f = 0; f < 3; f++) begin
      acc = 0; cyc = 0;
      while (acc < 64 && cyc < 300) begin
        step(1'b1, 10'($urandom_range(1023)), 10'($urandom_range(1023)),
             1'(wcnt == 63), 1'b1);
        cyc++;
        if (s_wr_fire) acc++;
      end
      n_checks++;
      if (err_frame !== 1'b1 || acc != 64) begin
        n_fail++;
        $display("FAIL err_sticky got err=%b acc=%0d exp 1 64",
                 err_frame, acc);
      end
    end
    drain(400, 100, done, lasts, gaps);
    n_checks++;
    if (!done || err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL err_drain got done=%0b err=%b exp 1 1", done, err_frame);
    end
  endtask

  task automatic test_random_stall();
    int  acc, cyc, lasts, gaps;
    bit  done;
    rst = 1'b1;
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    rst = 1'b0;
    model_clear();
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b exp 0", err_frame);
    end
    acc = 0; cyc = 0;
    while (acc < 1280 && cyc < 20000) begin
      step(1'($urandom_range(1)), 10'($urandom_range(1023)),
           10'($urandom_range(1023)), 1'(wcnt == 63),
           1'($urandom_range(1)));
      cyc++;
      if (s_wr_fire) acc++;
    end
    drain(3000, 50, done, lasts, gaps);
    n_checks++;
    if (acc != 1280 || !done || err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_run got acc=%0d done=%0b err=%b exp 1280 1 0",
               acc, done, err_frame);
    end
  endtask

  task automatic test_mid_reset();
    int  rd0, lasts, gaps;
    bit  done;
    for (int k = 0; k < 84; k++)
      step(1'b1, 10'($urandom_range(1023)), 10'($urandom_range(1023)),
           1'(wcnt == 63), 1'b0);
    rst = 1'b1;
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    rst = 1'b0;
    model_clear();
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
    n_checks++;
    if (s_dout_vld !== 1'b0 || s_din_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got vld=%b rdy=%b exp 0 1",
               s_dout_vld, s_din_rdy);
    end
    rd0 = rd_total;
    for (int k = 0; k < 64; k++)
      step(1'b1, 10'(k * 7 + 3), 10'(1000 - k), 1'(k == 63), 1'b1);
    drain(200, 100, done, lasts, gaps);
    step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
    n_checks++;
    if (!done || rd_total - rd0 != 64 || s_dout_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_refill got done=%0b reads=%0d vld=%b exp 1 64 0",
               done, rd_total - rd0, s_dout_vld);
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.din_vld  = 1'b0;
    bus.din_last = 1'b0;
    bus.din_re   = '0;
    bus.din_im   = '0;
    bus.dout_rdy = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_one_frame();
    test_backpressure();
    test_overlap();
    test_framing();
    test_random_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
